// File: rtl/ram_access_scheduler_if.sv
// Handshake and RAM-port bundle for ram_access_scheduler.
// The slave side is the scheduler; the master side is requesters plus the RAM.
interface ram_access_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 32
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    logic                  wr0_req;
    logic [RW-1:0]         wr0_row;
    logic [CW-1:0]         wr0_col;
    logic [DATA_WIDTH-1:0] wr0_data;
    logic                  wr0_ack;
    logic                  wr1_req;
    logic [RW-1:0]         wr1_row;
    logic [CW-1:0]         wr1_col;
    logic [DATA_WIDTH-1:0] wr1_data;
    logic                  wr1_ack;
    logic                  rd_req;
    logic [RW-1:0]         rd_row;
    logic [CW-1:0]         rd_col;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  ram_we;
    logic [RW-1:0]         ram_w_row;
    logic [CW-1:0]         ram_w_col;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [RW-1:0]         ram_r_row;
    logic [CW-1:0]         ram_r_col;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  wr0_req, wr0_row, wr0_col, wr0_data,
        input  wr1_req, wr1_row, wr1_col, wr1_data,
        input  rd_req, rd_row, rd_col, clr_req, ram_dout,
        output wr0_ack, wr1_ack, rd_valid, rd_data, clr_busy,
        output ram_we, ram_w_row, ram_w_col, ram_din, ram_r_row, ram_r_col
    );

    modport master (
        output wr0_req, wr0_row, wr0_col, wr0_data,
        output wr1_req, wr1_row, wr1_col, wr1_data,
        output rd_req, rd_row, rd_col, clr_req, ram_dout,
        input  wr0_ack, wr1_ack, rd_valid, rd_data, clr_busy,
        input  ram_we, ram_w_row, ram_w_col, ram_din, ram_r_row, ram_r_col
    );
endinterface

// File: rtl/ram_access_scheduler.sv
// Owns both ports of the row/column scratch RAM: round-robin write arbitration
// between two requesters, a 2-cycle pipelined read channel and a whole-memory clear.
module ram_access_scheduler #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    ram_access_scheduler_if.slave        bus
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state;
    logic          rr_ptr;
    logic          rd_p1;
    logic [RW-1:0] clr_row;
    logic [CW-1:0] clr_col;

    logic          elig0_c, elig1_c, grant0_c, grant1_c;
    logic          clr_last_c, col_wrap_c;
    logic [RW-1:0] clr_row_nxt_c;
    logic [CW-1:0] clr_col_nxt_c;

    // A requester whose ack is currently high is skipped, so it never wins twice in a row.
    assign elig0_c  = bus.wr0_req & ~bus.wr0_ack;
    assign elig1_c  = bus.wr1_req & ~bus.wr1_ack;
    assign grant0_c = elig0_c & (~elig1_c | ~rr_ptr);
    assign grant1_c = elig1_c & (~elig0_c |  rr_ptr);

    assign col_wrap_c    = (clr_col == CW'(COLS - 1));
    assign clr_last_c    = col_wrap_c && (clr_row == RW'(ROWS - 1));
    assign clr_col_nxt_c = col_wrap_c ? '0 : clr_col + CW'(1);
    assign clr_row_nxt_c = col_wrap_c ? clr_row + RW'(1) : clr_row;

    assign bus.rd_data = bus.ram_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            rd_p1         <= 1'b0;
            clr_row       <= '0;
            clr_col       <= '0;
            bus.wr0_ack   <= 1'b0;
            bus.wr1_ack   <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.clr_busy  <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_w_row <= '0;
            bus.ram_w_col <= '0;
            bus.ram_din   <= '0;
            bus.ram_r_row <= '0;
            bus.ram_r_col <= '0;
        end else begin
            bus.wr0_ack <= 1'b0;
            bus.wr1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        // First clear write goes out on the entry edge, at cell (0,0).
                        state         <= CLEAR;
                        bus.clr_busy  <= 1'b1;
                        bus.ram_we    <= 1'b1;
                        bus.ram_w_row <= '0;
                        bus.ram_w_col <= '0;
                        bus.ram_din   <= '0;
                        clr_row       <= '0;
                        clr_col       <= '0;
                    end else if (grant0_c) begin
                        bus.ram_we    <= 1'b1;
                        bus.ram_w_row <= bus.wr0_row;
                        bus.ram_w_col <= bus.wr0_col;
                        bus.ram_din   <= bus.wr0_data;
                        bus.wr0_ack   <= 1'b1;
                        rr_ptr        <= 1'b1;
                    end else if (grant1_c) begin
                        bus.ram_we    <= 1'b1;
                        bus.ram_w_row <= bus.wr1_row;
                        bus.ram_w_col <= bus.wr1_col;
                        bus.ram_din   <= bus.wr1_data;
                        bus.wr1_ack   <= 1'b1;
                        rr_ptr        <= 1'b0;
                    end else begin
                        bus.ram_we    <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_last_c) begin
                        state        <= IDLE;
                        bus.clr_busy <= 1'b0;
                        bus.ram_we   <= 1'b0;
                    end else begin
                        clr_row       <= clr_row_nxt_c;
                        clr_col       <= clr_col_nxt_c;
                        bus.ram_we    <= 1'b1;
                        bus.ram_w_row <= clr_row_nxt_c;
                        bus.ram_w_col <= clr_col_nxt_c;
                        bus.ram_din   <= '0;
                    end
                end
            endcase

            // Read pipeline runs regardless of state; the RAM adds the second cycle.
            if (bus.rd_req) begin
                bus.ram_r_row <= bus.rd_row;
                bus.ram_r_col <= bus.rd_col;
            end
            rd_p1        <= bus.rd_req;
            bus.rd_valid <= rd_p1;
        end
    end
endmodule

// File: tb/tb_ram_access_scheduler.sv
// Scoreboard bench for ram_access_scheduler: queue-driven requesters and reader,
// a behavioural RAM, and a monitor that checks every write and read against expectations.
module tb_ram_access_scheduler;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ROWS       = 4;
    localparam int unsigned COLS       = 32;
    localparam int unsigned RW         = $clog2(ROWS);
    localparam int unsigned CW         = $clog2(COLS);

    logic clk;
    logic rst;

    ram_access_scheduler_if #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .COLS(COLS)) bus ();

    ram_access_scheduler #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int                    port;
        logic [RW-1:0]         row;
        logic [CW-1:0]         col;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        int                    cyc;
    } rd_t;

    wr_t q0[$];
    wr_t q1[$];
    wr_t rq[$];
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    int  ack1_log[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int fall_cyc = -1;

    logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: registered read, read-before-write on a shared edge.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_w_row][bus.ram_w_col] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_r_row][bus.ram_r_col];
    end

    function automatic wr_t mk(input int port, input int row, input int col, input int data);
        wr_t w;
        w.port = port;
        w.row  = RW'(row);
        w.col  = CW'(col);
        w.data = DATA_WIDTH'(data);
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + rq.size() + exp_wr.size() + exp_rd.size()) != 0
               && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_in_time", 32'(n < max_cyc), 1);
        repeat (3) step();
    endtask

    task automatic push_clear();
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
                exp_wr.push_back(mk(2, r, c, 0));
    endtask

    // Requester 0: presents the head of q0, advances when its ack is seen.
    initial begin
        bus.wr0_req = 1'b0; bus.wr0_row = '0; bus.wr0_col = '0; bus.wr0_data = '0;
        forever begin
            @(negedge clk);
            if (bus.wr0_ack && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                bus.wr0_req = 1'b1; bus.wr0_row = q0[0].row;
                bus.wr0_col = q0[0].col; bus.wr0_data = q0[0].data;
            end else begin
                bus.wr0_req = 1'b0;
            end
        end
    end

    initial begin
        bus.wr1_req = 1'b0; bus.wr1_row = '0; bus.wr1_col = '0; bus.wr1_data = '0;
        forever begin
            @(negedge clk);
            if (bus.wr1_ack && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                bus.wr1_req = 1'b1; bus.wr1_row = q1[0].row;
                bus.wr1_col = q1[0].col; bus.wr1_data = q1[0].data;
            end else begin
                bus.wr1_req = 1'b0;
            end
        end
    end

    // Reader: one read per cycle from rq; expected data due two cycles later.
    initial begin
        wr_t r;
        rd_t e;
        bus.rd_req = 1'b0; bus.rd_row = '0; bus.rd_col = '0;
        forever begin
            @(negedge clk);
            if (rq.size() > 0) begin
                r = rq.pop_front();
                bus.rd_req = 1'b1; bus.rd_row = r.row; bus.rd_col = r.col;
                e.data = r.data;
                e.cyc  = cyc + 2;
                exp_rd.push_back(e);
            end else begin
                bus.rd_req = 1'b0;
            end
        end
    end

    // Monitor: compares every RAM write and every read result against the queues.
    initial begin
        wr_t  w;
        rd_t  e;
        int   last_a0 = -10;
        int   last_a1 = -10;
        logic prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rd_valid) begin
                    if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
                    else begin
                        e = exp_rd.pop_front();
                        check("rd_data", 32'(bus.rd_data), 32'(e.data));
                        check("rd_latency", 32'(cyc), 32'(e.cyc));
                    end
                end
                if (bus.ram_we) begin
                    if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
                    else begin
                        w = exp_wr.pop_front();
                        check("wr_row", 32'(bus.ram_w_row), 32'(w.row));
                        check("wr_col", 32'(bus.ram_w_col), 32'(w.col));
                        check("wr_data", 32'(bus.ram_din), 32'(w.data));
                        check("wr_ack0", 32'(bus.wr0_ack), 32'(w.port == 0));
                        check("wr_ack1", 32'(bus.wr1_ack), 32'(w.port == 1));
                        check("wr_clr_busy", 32'(bus.clr_busy), 32'(w.port == 2));
                    end
                end else begin
                    check("ack_without_we", 32'({bus.wr0_ack, bus.wr1_ack}), 0);
                end
                if (bus.wr0_ack) begin
                    check("ack0_not_b2b", 32'((cyc - last_a0) >= 2), 1);
                    last_a0 = cyc;
                end
                if (bus.wr1_ack) begin
                    check("ack1_not_b2b", 32'((cyc - last_a1) >= 2), 1);
                    last_a1 = cyc;
                    ack1_log.push_back(cyc);
                end
                if (bus.clr_busy) busy_cnt++;
                if (prev_busy && !bus.clr_busy) fall_cyc = cyc;
                prev_busy = bus.clr_busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
                mem[r][c] = '0;
        rst = 1'b1;
        bus.clr_req = 1'b0;
        repeat (3) step();

        // Reset values
        check("rst_ack0", 32'(bus.wr0_ack), 0);
        check("rst_ack1", 32'(bus.wr1_ack), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_clr_busy", 32'(bus.clr_busy), 0);
        check("rst_ram_we", 32'(bus.ram_we), 0);
        check("rst_w_addr", 32'({bus.ram_w_row, bus.ram_w_col}), 0);
        check("rst_din", 32'(bus.ram_din), 0);
        check("rst_r_addr", 32'({bus.ram_r_row, bus.ram_r_col}), 0);
        rst = 1'b0;
        step();

        // Single write then read-back
        q0.push_back(mk(0, 1, 5, 8'hA5));
        exp_wr.push_back(mk(0, 1, 5, 8'hA5));
        wait_drain(20);
        rq.push_back(mk(0, 1, 5, 8'hA5));
        wait_drain(20);

        // Both requesters held from reset: 0,1,0,1,...
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 0, 2 * i, 8'h10 + 2 * i));
            q1.push_back(mk(1, 0, 2 * i + 1, 8'h11 + 2 * i));
            exp_wr.push_back(mk(0, 0, 2 * i, 8'h10 + 2 * i));
            exp_wr.push_back(mk(1, 0, 2 * i + 1, 8'h11 + 2 * i));
        end
        step();
        step();
        rst = 1'b0;
        wait_drain(40);

        // One wr0 alone moves rr_ptr to wr1, so the next contention starts with wr1
        q0.push_back(mk(0, 0, 8, 8'h20));
        exp_wr.push_back(mk(0, 0, 8, 8'h20));
        wait_drain(20);
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(0, 0, 9 + 2 * i, 8'h21 + 2 * i));
            q1.push_back(mk(1, 0, 10 + 2 * i, 8'h22 + 2 * i));
            exp_wr.push_back(mk(1, 0, 10 + 2 * i, 8'h22 + 2 * i));
            exp_wr.push_back(mk(0, 0, 9 + 2 * i, 8'h21 + 2 * i));
        end
        wait_drain(40);

        // Single requester held high: grants exactly every other cycle
        ack1_log.delete();
        for (int i = 0; i < 4; i++) begin
            q1.push_back(mk(1, 3, 20 + i, 8'h31 + i));
            exp_wr.push_back(mk(1, 3, 20 + i, 8'h31 + i));
        end
        wait_drain(40);
        check("single_ack_count", 32'(ack1_log.size()), 4);
        for (int i = 1; i < ack1_log.size(); i++)
            check("single_ack_gap", 32'(ack1_log[i] - ack1_log[i-1]), 2);

        // Clear with wr1 pending and a mid-clear clr_req pulse
        ack1_log.delete();
        busy_cnt = 0;
        bus.clr_req = 1'b1;
        q1.push_back(mk(1, 1, 6, 8'h5A));
        push_clear();
        exp_wr.push_back(mk(1, 1, 6, 8'h5A));
        step();
        bus.clr_req = 1'b0;
        repeat (50) step();
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        wait_drain(200);
        check("clear_busy_cycles", 32'(busy_cnt), 128);
        check("clear_wr1_acks", 32'(ack1_log.size()), 1);
        if (ack1_log.size() > 0)
            check("clear_wr1_ack_cycle", 32'(ack1_log[0]), 32'(fall_cyc + 1));
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
                rq.push_back(mk(0, r, c, (r == 1 && c == 6) ? 8'h5A : 8'h00));
        wait_drain(200);

        // Back-to-back reads during alternating writes; first read hits a same-edge write
        q0.push_back(mk(0, 2, 0, 8'h11));
        q0.push_back(mk(0, 2, 1, 8'h22));
        q1.push_back(mk(1, 3, 0, 8'h33));
        q1.push_back(mk(1, 3, 1, 8'h44));
        exp_wr.push_back(mk(0, 2, 0, 8'h11));
        exp_wr.push_back(mk(1, 3, 0, 8'h33));
        exp_wr.push_back(mk(0, 2, 1, 8'h22));
        exp_wr.push_back(mk(1, 3, 1, 8'h44));
        rq.push_back(mk(0, 2, 0, 8'h00));
        rq.push_back(mk(0, 2, 0, 8'h11));
        rq.push_back(mk(0, 3, 0, 8'h33));
        rq.push_back(mk(0, 1, 5, 8'h00));
        wait_drain(40);

        // Reset 40 writes into a clear, then a fresh clear from (0,0)
        push_clear();
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        begin
            int n;
            n = 0;
            while (exp_wr.size() > 88 && n < 100) begin
                step();
                n++;
            end
            check("clear40_reached", 32'(n < 100), 1);
        end
        rst = 1'b1;
        #1;
        check("midclr_ram_we", 32'(bus.ram_we), 0);
        check("midclr_clr_busy", 32'(bus.clr_busy), 0);
        check("midclr_acks", 32'({bus.wr0_ack, bus.wr1_ack}), 0);
        check("midclr_rd_valid", 32'(bus.rd_valid), 0);
        exp_wr.delete();
        step();
        step();
        rst = 1'b0;
        step();
        busy_cnt = 0;
        push_clear();
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        wait_drain(200);
        check("reclear_busy_cycles", 32'(busy_cnt), 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
